// File: rtl/imem_loader_pkg.sv
// Shared constants and types for the byte-stream instruction-memory loader.
// Frame: SYNC | N lo | N hi | N little-endian words | 8-bit payload byte sum.
package imem_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StCntLo,
        StCntHi,
        StData,
        StCsum,
        StDone,
        StErr
    } state_t;

    localparam logic [1:0] ErrNone   = 2'd0;
    localparam logic [1:0] ErrLength = 2'd1;
    localparam logic [1:0] ErrCsum   = 2'd2;

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// Packs bytes LSB-first into 32-bit words; word and word_done are registered
// one cycle after the fourth byte of a word is taken.
module imem_loader_byte_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        last_byte,
    output logic        word_done,
    output logic [31:0] word
);

    logic [1:0]  lane_q;
    logic [23:0] shift_q;

    assign last_byte = (lane_q == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q    <= 2'd0;
            shift_q   <= 24'd0;
            word_done <= 1'b0;
            word      <= 32'd0;
        end else begin
            word_done <= 1'b0;
            if (clear) begin
                lane_q <= 2'd0;
            end else if (byte_en) begin
                shift_q <= {byte_in, shift_q[23:8]};
                lane_q  <= lane_q + 2'd1;
                if (last_byte) begin
                    word      <= {byte_in, shift_q};
                    word_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction memory; holds the CPU in reset
// while a frame is loading and releases it only on a valid checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W        = 8,
    parameter bit          HOLD_AT_RESET = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int unsigned IDX_W     = ADDR_W + 1;
    localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

    state_t           state;
    logic [7:0]       n_lo_q;
    logic [IDX_W-1:0] n_words_q;
    logic [IDX_W-1:0] word_idx_q;
    logic [IDX_W-1:0] idx_next;
    logic [7:0]       csum_q;
    logic [15:0]      n_full;
    logic             xfer;
    logic             last_byte;
    logic             byte_en;
    logic             sync_seen;

    assign in_ready  = (state != StDone) && (state != StErr);
    assign busy      = (state != StIdle);
    assign xfer      = in_valid && in_ready;
    assign n_full    = {in_data, n_lo_q};
    assign idx_next  = word_idx_q + IDX_W'(1);
    assign byte_en   = xfer && (state == StData);
    assign sync_seen = xfer && (state == StIdle) && (in_data == SYNC_BYTE);

    imem_loader_byte_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (sync_seen),
        .byte_en   (byte_en),
        .byte_in   (in_data),
        .last_byte (last_byte),
        .word_done (im_we),
        .word      (im_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            n_lo_q     <= 8'd0;
            n_words_q  <= '0;
            word_idx_q <= '0;
            csum_q     <= 8'd0;
            im_addr    <= '0;
            cpu_hold   <= HOLD_AT_RESET;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= ErrNone;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (sync_seen) begin
                        state    <= StCntLo;
                        cpu_hold <= 1'b1;
                        err_code <= ErrNone;
                        csum_q   <= 8'd0;
                    end
                end
                StCntLo: begin
                    if (xfer) begin
                        n_lo_q <= in_data;
                        state  <= StCntHi;
                    end
                end
                StCntHi: begin
                    if (xfer) begin
                        n_words_q <= IDX_W'(n_full);
                        if (32'(n_full) > MAX_WORDS) begin
                            state    <= StErr;
                            err      <= 1'b1;
                            err_code <= ErrLength;
                        end else if (n_full == 16'd0) begin
                            state <= StCsum;
                        end else begin
                            state      <= StData;
                            word_idx_q <= '0;
                        end
                    end
                end
                StData: begin
                    if (xfer) begin
                        csum_q <= csum_q + in_data;
                        if (last_byte) begin
                            // Address is registered alongside the packer's word, so both land
                            // together with im_we one cycle after the 4th byte.
                            im_addr    <= word_idx_q[ADDR_W-1:0];
                            word_idx_q <= idx_next;
                            if (idx_next == n_words_q) begin
                                state <= StCsum;
                            end
                        end
                    end
                end
                StCsum: begin
                    if (xfer) begin
                        if (in_data == csum_q) begin
                            state <= StDone;
                            done  <= 1'b1;
                        end else begin
                            state    <= StErr;
                            err      <= 1'b1;
                            err_code <= ErrCsum;
                        end
                    end
                end
                StDone: begin
                    cpu_hold <= 1'b0;
                    state    <= StIdle;
                end
                StErr: begin
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Frame-level bench: expected writes and outcomes come from the frame contents.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    int tests = 0;
    int fails = 0;
    int done_seen = 0;

    int          exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_out[$];   // 3 = done, 1 = length error, 2 = checksum error
    logic [31:0] pay[$];

    imem_loader #(
        .ADDR_W        (8),
        .HOLD_AT_RESET (1'b0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] model_csum();
        logic [7:0] s = 8'd0;
        foreach (pay[i]) s = s + pay[i][7:0] + pay[i][15:8] + pay[i][23:16] + pay[i][31:24];
        return s;
    endfunction

    // Compare process: every write and every done/err pulse must match the expectation queues.
    initial begin
        int o;
        int got;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (im_we) begin
                    if (exp_addr.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_write: addr %0d data %h, none expected",
                                 im_addr, im_wdata);
                    end else begin
                        check("wr_addr", 32'(im_addr), 32'(exp_addr.pop_front()));
                        check("wr_data", im_wdata, exp_data.pop_front());
                    end
                end
                if (done || err) begin
                    if (done) done_seen++;
                    got = done ? 3 : int'(err_code);
                    if (done && err) got = 0;
                    if (exp_out.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_outcome: got %0d, none expected", got);
                    end else begin
                        o = exp_out.pop_front();
                        check("outcome", 32'(got), 32'(o));
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int g;
        in_valid = 1'b0;
        g = (gap > 0) ? $urandom_range(gap, 0) : 0;
        repeat (g) begin
            in_data = 8'hA5;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: in_ready got 0 required 1");
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic fill_pay(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back($urandom);
    endtask

    // Sends a frame with N = n (pay must hold n words when n <= 256), then checks settle state.
    task automatic send_frame(input int n, input logic [7:0] cs_xor, input int gap);
        logic [7:0] cs;
        logic [15:0] nn;
        int outcome;
        nn = 16'(n);
        cs = model_csum() ^ cs_xor;
        if (n > 256) begin
            outcome = 1;
        end else begin
            outcome = (cs_xor == 8'd0) ? 3 : 2;
            for (int i = 0; i < n; i++) begin
                exp_addr.push_back(i);
                exp_data.push_back(pay[i]);
            end
        end
        exp_out.push_back(outcome);
        send_byte(8'hA5, gap);
        check("hold_in_frame", 32'(cpu_hold), 32'd1);
        check("busy_in_frame", 32'(busy), 32'd1);
        send_byte(nn[7:0], gap);
        send_byte(nn[15:8], gap);
        if (n <= 256) begin
            for (int i = 0; i < n; i++) begin
                for (int j = 0; j < 4; j++) send_byte(8'(pay[i] >> (8 * j)), gap);
            end
            send_byte(cs, gap);
        end
        @(negedge clk);
        @(negedge clk);
        check("hold_after", 32'(cpu_hold), (outcome == 3) ? 32'd0 : 32'd1);
        check("busy_after", 32'(busy), 32'd0);
        check("err_code_after", 32'(err_code), (outcome == 3) ? 32'd0 : 32'(outcome));
        check("writes_drained", 32'(exp_addr.size()), 32'd0);
        check("outcome_drained", 32'(exp_out.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] x;
        int n;
        int d0;

        repeat (3) @(negedge clk);
        check("rst_we", 32'(im_we), 32'd0);
        check("rst_addr", 32'(im_addr), 32'd0);
        check("rst_wdata", im_wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_err", {30'd0, done, err}, 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Good load from the reference frame.
        pay.delete();
        pay.push_back(32'h00500013);
        pay.push_back(32'h00100093);
        check("model_csum_t1", 32'(model_csum()), 32'h06);
        d0 = done_seen;
        send_frame(2, 8'h00, 0);
        check("t1_done_count", 32'(done_seen - d0), 32'd1);

        // Same frame, checksum byte 07.
        send_frame(2, 8'h01, 0);

        // Empty frames.
        pay.delete();
        send_frame(0, 8'h00, 0);
        send_frame(0, 8'h01, 0);

        // Length overflow: N = 0x0101, then trailing non-sync bytes ignored.
        send_frame(257, 8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        send_byte(8'h50, 0);
        check("t4_idle", 32'(busy), 32'd0);

        // Garbage then the reference frame with bubbles.
        send_byte(8'h00, 2);
        send_byte(8'hFF, 2);
        send_byte(8'h3C, 2);
        check("t5_idle", 32'(busy), 32'd0);
        pay.delete();
        pay.push_back(32'h00500013);
        pay.push_back(32'h00100093);
        send_frame(2, 8'h00, 3);

        // Reset after 6 payload bytes: only word 0 may be written.
        exp_addr.push_back(0);
        exp_data.push_back(32'h11223344);
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h44, 0);
        send_byte(8'h33, 0);
        send_byte(8'h22, 0);
        send_byte(8'h11, 0);
        send_byte(8'h88, 0);
        send_byte(8'h77, 0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_hold", 32'(cpu_hold), 32'd0);
        check("t6_we", 32'(im_we), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_one_write", 32'(exp_addr.size()), 32'd0);
        fill_pay(3);
        send_frame(3, 8'h00, 1);

        // Exact fill of the 256-word memory.
        fill_pay(256);
        send_frame(256, 8'h00, 0);

        // Randomized frames with garbage between them.
        for (int i = 0; i < 12; i++) begin
            for (int g = 0; g < int'($urandom_range(3, 0)); g++) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h00;
                send_byte(b, 2);
            end
            if (i == 5) begin
                n = $urandom_range(2000, 257);
            end else begin
                n = $urandom_range(7, 0);
            end
            fill_pay((n > 256) ? 0 : n);
            x = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            send_frame(n, x, $urandom_range(2, 0));
        end

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
